// File: rtl/div_sequencer.sv
// div_sequencer: request/response wrapper around an SRT4 divider.
// Prepares operands, short-cuts special cases and reuses the last result.
module div_sequencer #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       in_op_i,
  input  logic             in_word_i,
  input  logic [WIDTH-1:0] in_dividend_i,
  input  logic [WIDTH-1:0] in_divisor_i,
  input  logic [TAG_W-1:0] in_tag_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_result_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             div_start_o,
  output logic             div_sign_o,
  output logic [WIDTH-1:0] div_dividend_o,
  output logic [WIDTH-1:0] div_divisor_o,
  input  logic             div_finish_i,
  input  logic [WIDTH-1:0] div_q_i,
  input  logic [WIDTH-1:0] div_rem_i
);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_FALL,
    BUSY,
    DONE,
    DRAIN
  } state_e;

  localparam logic [WIDTH-1:0] MIN_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             word_q, word_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             fell_q, fell_d;

  logic             rv_q, rv_d;
  logic             rsign_q, rsign_d;
  logic             rword_q, rword_d;
  logic [WIDTH-1:0] rdvd_q, rdvd_d;
  logic [WIDTH-1:0] rdvs_q, rdvs_d;
  logic [WIDTH-1:0] rquo_q, rquo_d;
  logic [WIDTH-1:0] rrem_q, rrem_d;

  logic             in_sign;
  logic             ext_a, ext_b;
  logic [WIDTH-1:0] p_dvd, p_dvs;
  logic             div0, ovf, hit;
  logic [WIDTH-1:0] sp_q, sp_r;

  // Selects quotient or remainder; W results are sign-extended from bit 31.
  function automatic logic [WIDTH-1:0] fmt(
    input logic             rem_sel,
    input logic             w,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] r
  );
    logic [WIDTH-1:0] v;
    v = rem_sel ? r : q;
    if (w) v = {{(WIDTH-32){v[31]}}, v[31:0]};
    return v;
  endfunction

  assign in_sign = ~in_op_i[0];
  assign ext_a   = in_sign & in_dividend_i[31];
  assign ext_b   = in_sign & in_divisor_i[31];

  assign p_dvd = in_word_i
    ? {{(WIDTH-32){ext_a}}, in_dividend_i[31:0]}
    : in_dividend_i;
  assign p_dvs = in_word_i
    ? {{(WIDTH-32){ext_b}}, in_divisor_i[31:0]}
    : in_divisor_i;

  assign div0 = (p_dvs == '0);

  assign ovf = in_sign & (in_word_i
    ? (in_dividend_i[31:0] == 32'h8000_0000 &&
       in_divisor_i[31:0] == 32'hFFFF_FFFF)
    : (in_dividend_i == MIN_NEG &&
       in_divisor_i == '1));

  assign hit = rv_q & ~flush_i
             & (p_dvd == rdvd_q)
             & (p_dvs == rdvs_q)
             & (in_sign == rsign_q)
             & (in_word_i == rword_q);

  // Quotient/remainder pair for requests that bypass the divider.
  always_comb begin
    sp_q = rquo_q;
    sp_r = rrem_q;
    if (div0) begin
      sp_q = '1;
      sp_r = p_dvd;
    end else if (ovf) begin
      sp_q = p_dvd;
      sp_r = '0;
    end
  end

  // Sequencer next state, operand capture and reuse-store update.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    word_d  = word_q;
    tag_d   = tag_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    fell_d  = fell_q;
    rv_d    = rv_q;
    rsign_d = rsign_q;
    rword_d = rword_q;
    rdvd_d  = rdvd_q;
    rdvs_d  = rdvs_q;
    rquo_d  = rquo_q;
    rrem_d  = rrem_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          op_d   = in_op_i;
          word_d = in_word_i;
          tag_d  = in_tag_i;
          dvd_d  = p_dvd;
          dvs_d  = p_dvs;
          if (div0 | ovf | hit) begin
            res_d   = fmt(in_op_i[1], in_word_i,
                          sp_q, sp_r);
            state_d = DONE;
          end else begin
            rv_d    = 1'b0;
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        fell_d  = 1'b0;
        state_d = flush_i ? DRAIN : WAIT_FALL;
      end
      WAIT_FALL: begin
        if (flush_i) begin
          fell_d  = ~div_finish_i;
          state_d = DRAIN;
        end else if (!div_finish_i) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (flush_i) begin
          fell_d  = 1'b1;
          state_d = DRAIN;
        end else if (div_finish_i) begin
          res_d   = fmt(op_q[1], word_q,
                        div_q_i, div_rem_i);
          rv_d    = 1'b1;
          rsign_d = ~op_q[0];
          rword_d = word_q;
          rdvd_d  = dvd_q;
          rdvs_d  = dvs_q;
          rquo_d  = div_q_i;
          rrem_d  = div_rem_i;
          state_d = DONE;
        end
      end
      DONE: begin
        if (flush_i || out_ready_i) state_d = IDLE;
      end
      DRAIN: begin
        if (!fell_q) begin
          if (!div_finish_i) fell_d = 1'b1;
        end else if (div_finish_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      op_q    <= '0;
      word_q  <= 1'b0;
      tag_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      fell_q  <= 1'b0;
      rv_q    <= 1'b0;
      rsign_q <= 1'b0;
      rword_q <= 1'b0;
      rdvd_q  <= '0;
      rdvs_q  <= '0;
      rquo_q  <= '0;
      rrem_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      word_q  <= word_d;
      tag_q   <= tag_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      fell_q  <= fell_d;
      rv_q    <= rv_d;
      rsign_q <= rsign_d;
      rword_q <= rword_d;
      rdvd_q  <= rdvd_d;
      rdvs_q  <= rdvs_d;
      rquo_q  <= rquo_d;
      rrem_q  <= rrem_d;
    end
  end

  assign in_ready_o     = (state_q == IDLE);
  assign out_valid_o    = (state_q == DONE);
  assign div_start_o    = (state_q == LAUNCH);
  assign div_sign_o     = ~op_q[0];
  assign div_dividend_o = dvd_q;
  assign div_divisor_o  = dvs_q;
  assign out_result_o   = res_q;
  assign out_tag_o      = tag_q;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: scoreboard bench for div_sequencer
// with a behavioural SRT4 divider stand-in.
module tb_div_sequencer;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  tag;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready_o;
  logic [1:0]  in_op = '0;
  logic        in_word = 1'b0;
  logic [63:0] in_dvd = '0;
  logic [63:0] in_dvs = '0;
  logic [4:0]  in_tag = '0;
  logic        flush = 1'b0;
  logic        out_valid_o;
  logic        out_ready = 1'b1;
  logic [63:0] out_result_o;
  logic [4:0]  out_tag_o;
  logic        div_start_o;
  logic        div_sign_o;
  logic [63:0] div_dividend_o;
  logic [63:0] div_divisor_o;
  logic        div_fin;
  logic [63:0] div_q;
  logic [63:0] div_rem;

  int   n_checks = 0;
  int   n_fail = 0;
  int   lat = 5;
  int   cnt;
  int   start_cnt = 0;
  int   dbl_cnt = 0;
  logic start_prev = 1'b0;
  rec_t sb[$];
  rec_t obs[$];
  logic [63:0] mq, mr;

  always #5 clk = ~clk;

  div_sequencer #(.WIDTH(64), .TAG_W(5)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready_o),
    .in_op_i        (in_op),
    .in_word_i      (in_word),
    .in_dividend_i  (in_dvd),
    .in_divisor_i   (in_dvs),
    .in_tag_i       (in_tag),
    .flush_i        (flush),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready),
    .out_result_o   (out_result_o),
    .out_tag_o      (out_tag_o),
    .div_start_o    (div_start_o),
    .div_sign_o     (div_sign_o),
    .div_dividend_o (div_dividend_o),
    .div_divisor_o  (div_divisor_o),
    .div_finish_i   (div_fin),
    .div_q_i        (div_q),
    .div_rem_i      (div_rem)
  );

  // Divider stand-in arithmetic on the operands the DUT presents.
  always_comb begin
    mq = '1;
    mr = div_dividend_o;
    if (div_divisor_o != '0) begin
      if (div_sign_o) begin
        if (div_dividend_o == 64'h8000_0000_0000_0000 &&
            div_divisor_o == '1) begin
          mq = div_dividend_o;
          mr = '0;
        end else begin
          mq = $signed(div_dividend_o) / $signed(div_divisor_o);
          mr = $signed(div_dividend_o) % $signed(div_divisor_o);
        end
      end else begin
        mq = div_dividend_o / div_divisor_o;
        mr = div_dividend_o % div_divisor_o;
      end
    end
  end

  // Divider stand-in: finish drops after start, rises lat+1 cycles later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_fin <= 1'b1;
      cnt     <= 0;
      div_q   <= '0;
      div_rem <= '0;
    end else if (div_start_o) begin
      div_fin <= 1'b0;
      cnt     <= lat;
    end else if (!div_fin) begin
      if (cnt == 0) begin
        div_fin <= 1'b1;
        div_q   <= mq;
        div_rem <= mr;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  // Start-pulse bookkeeping.
  always @(posedge clk) begin
    if (div_start_o) start_cnt <= start_cnt + 1;
    if (div_start_o && start_prev) dbl_cnt <= dbl_cnt + 1;
    start_prev <= div_start_o;
  end

  // RISC-V M-extension reference for all four ops and W variants.
  function automatic logic [63:0] ref_div(
    input logic [1:0]  op,
    input logic        w,
    input logic [63:0] a,
    input logic [63:0] b
  );
    logic [63:0] x, y, q, r, v;
    logic s;
    s = !op[0];
    x = a;
    y = b;
    if (w) begin
      x = s ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]};
      y = s ? {{32{b[31]}}, b[31:0]} : {32'b0, b[31:0]};
    end
    if (y == 0) begin
      q = '1;
      r = x;
    end else if (s && x == 64'h8000_0000_0000_0000 && y == '1) begin
      q = x;
      r = '0;
    end else if (s) begin
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end else begin
      q = x / y;
      r = x % y;
    end
    v = op[1] ? r : q;
    if (w) v = {{32{v[31]}}, v[31:0]};
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(
    input  logic [1:0]  op,
    input  logic        w,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [4:0]  tag,
    input  bit          push,
    output bit          ok
  );
    in_valid = 1'b1;
    in_op    = op;
    in_word  = w;
    in_dvd   = a;
    in_dvs   = b;
    in_tag   = tag;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (in_ready_o) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    if (ok) begin
      if (push) sb.push_back('{ref_div(op, w, a, b), tag});
      step(1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (obs.size() >= sb.size()) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(3);
    n_checks++;
    if (in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset in_ready: got %b want 1", in_ready_o);
    end
    n_checks++;
    if (out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset out_valid: got %b want 0", out_valid_o);
    end
    n_checks++;
    if (div_start_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset div_start: got %b want 0", div_start_o);
    end
    n_checks++;
    if (out_result_o !== 64'h0) begin
      n_fail++;
      $display("FAIL reset result: got %h want 0", out_result_o);
    end
    n_checks++;
    if (out_tag_o !== 5'd0) begin
      n_fail++;
      $display("FAIL reset tag: got %0d want 0", out_tag_o);
    end
    rst_n = 1'b1;
    step(2);
    n_checks++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post-reset idle: got rdy %b vld %b want 1 0",
               in_ready_o, out_valid_o);
    end
  endtask

  task automatic test_divu();
    bit ok;
    int s0, d0;
    rec_t e, o;
    s0 = start_cnt;
    d0 = dbl_cnt;
    issue(2'b01, 1'b0, 64'd100, 64'd7, 5'd3, 1'b1, ok);
    wait_out(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL divu timeout: got %0d outputs want %0d",
               obs.size(), sb.size());
    end
    n_checks++;
    if (start_cnt - s0 != 1 || dbl_cnt != d0) begin
      n_fail++;
      $display("FAIL divu start pulse: got %0d starts %0d long want 1 0",
               start_cnt - s0, dbl_cnt - d0);
    end
    while (sb.size() != 0 && obs.size() != 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL divu result: got %h/%0d want %h/%0d",
                 o.res, o.tag, e.res, e.tag);
      end
    end
  endtask

  task automatic test_reuse();
    bit ok;
    int s0;
    rec_t e, o;
    logic [63:0] a;
    a = -64'sd45;
    issue(2'b00, 1'b0, a, 64'd7, 5'd1, 1'b1, ok);
    wait_out(ok);
    s0 = start_cnt;
    issue(2'b10, 1'b0, a, 64'd7, 5'd2, 1'b1, ok);
    n_checks++;
    if (!ok || out_valid_o !== 1'b1 || start_cnt != s0) begin
      n_fail++;
      $display("FAIL reuse fast path: got vld %b starts %0d want 1 0",
               out_valid_o, start_cnt - s0);
    end
    wait_out(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL reuse timeout: got %0d want %0d",
               obs.size(), sb.size());
    end
    while (sb.size() != 0 && obs.size() != 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reuse result: got %h/%0d want %h/%0d",
                 o.res, o.tag, e.res, e.tag);
      end
    end
  endtask

  task automatic test_special();
    bit ok;
    int s0;
    rec_t e, o;
    logic [1:0]  ops [4];
    logic        ws  [4];
    logic [63:0] as  [4];
    logic [63:0] bs  [4];
    ops = '{2'b00, 2'b11, 2'b00, 2'b10};
    ws  = '{1'b0, 1'b0, 1'b1, 1'b0};
    as  = '{64'd5, 64'd5, 64'h0000_0000_8000_0000,
            64'h8000_0000_0000_0000};
    bs  = '{64'd0, 64'd0, 64'h0000_0000_FFFF_FFFF, '1};
    for (int i = 0; i < 4; i++) begin
      s0 = start_cnt;
      issue(ops[i], ws[i], as[i], bs[i], 5'(10 + i), 1'b1, ok);
      n_checks++;
      if (!ok || out_valid_o !== 1'b1 || start_cnt != s0) begin
        n_fail++;
        $display("FAIL special %0d latency: got vld %b starts %0d want 1 0",
                 i, out_valid_o, start_cnt - s0);
      end
      wait_out(ok);
    end
    n_checks++;
    if (sb.size() != 4 || sb[0].res !== '1 || sb[1].res !== 64'd5 ||
        sb[2].res !== 64'hFFFF_FFFF_8000_0000 || sb[3].res !== 64'd0) begin
      n_fail++;
      $display("FAIL special reference: got %0d entries want 4 fixed values",
               sb.size());
    end
    while (sb.size() != 0 && obs.size() != 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL special result: got %h/%0d want %h/%0d",
                 o.res, o.tag, e.res, e.tag);
      end
    end
  endtask

  task automatic test_flush_busy();
    bit ok, bad_vld, rdy_seen, fin_at_rdy, early;
    int s0;
    rec_t e, o;
    lat = 10;
    issue(2'b01, 1'b0, 64'd1000, 64'd3, 5'd7, 1'b0, ok);
    step(2);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    bad_vld = 1'b0;
    rdy_seen = 1'b0;
    fin_at_rdy = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid_o) bad_vld = 1'b1;
      if (in_ready_o) begin
        rdy_seen = 1'b1;
        fin_at_rdy = div_fin;
        early = (i < 5);
        break;
      end
      step(1);
    end
    n_checks++;
    if (bad_vld || !rdy_seen || !fin_at_rdy || early) begin
      n_fail++;
      $display("FAIL flush drain: got vld %b rdy %b fin %b early %b want 0 1 1 0",
               bad_vld, rdy_seen, fin_at_rdy, early);
    end
    s0 = start_cnt;
    issue(2'b01, 1'b0, 64'd1000, 64'd3, 5'd8, 1'b1, ok);
    wait_out(ok);
    n_checks++;
    if (!ok || start_cnt - s0 != 1) begin
      n_fail++;
      $display("FAIL flush next op: got ok %b starts %0d want 1 1",
               ok, start_cnt - s0);
    end
    while (sb.size() != 0 && obs.size() != 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL flush result: got %h/%0d want %h/%0d",
                 o.res, o.tag, e.res, e.tag);
      end
    end
    lat = 5;
  endtask

  task automatic test_backpressure();
    bit ok, seen, bad;
    rec_t e, o;
    out_ready = 1'b0;
    issue(2'b01, 1'b0, 64'd77, 64'd5, 5'd9, 1'b1, ok);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid_o) begin
        seen = 1'b1;
        break;
      end
      step(1);
    end
    bad = !seen;
    for (int i = 0; i < 10; i++) begin
      if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 ||
          out_result_o !== 64'd15 || out_tag_o !== 5'd9)
        bad = 1'b1;
      step(1);
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL backpressure hold: got %h/%0d vld %b rdy %b want 15/9 1 0",
               out_result_o, out_tag_o, out_valid_o, in_ready_o);
    end
    out_ready = 1'b1;
    wait_out(ok);
    while (sb.size() != 0 && obs.size() != 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL backpressure result: got %h/%0d want %h/%0d",
                 o.res, o.tag, e.res, e.tag);
      end
    end
  endtask

  task automatic test_flush_done();
    bit ok, seen;
    out_ready = 1'b0;
    issue(2'b01, 1'b0, 64'd50, 64'd6, 5'd4, 1'b0, ok);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid_o) begin
        seen = 1'b1;
        break;
      end
      step(1);
    end
    flush = 1'b1;
    out_ready = 1'b1;
    step(1);
    flush = 1'b0;
    n_checks++;
    if (!seen || in_ready_o !== 1'b1 || out_valid_o !== 1'b0 ||
        obs.size() != 0) begin
      n_fail++;
      $display("FAIL flush done: got seen %b rdy %b vld %b obs %0d want 1 1 0 0",
               seen, in_ready_o, out_valid_o, obs.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    rec_t e, o;
    lat = 20;
    issue(2'b01, 1'b0, 64'd9, 64'd2, 5'd5, 1'b0, ok);
    step(3);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 ||
        div_start_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset mid-op: got rdy %b vld %b start %b want 1 0 0",
               in_ready_o, out_valid_o, div_start_o);
    end
    step(1);
    rst_n = 1'b1;
    lat = 5;
    step(1);
    issue(2'b01, 1'b0, 64'd9, 64'd2, 5'd6, 1'b1, ok);
    wait_out(ok);
    while (sb.size() != 0 && obs.size() != 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset-mid result: got %h/%0d want %h/%0d",
                 o.res, o.tag, e.res, e.tag);
      end
    end
  endtask

  task automatic test_word_random();
    bit ok;
    rec_t e, o;
    logic [1:0]  op, pop;
    logic        w, pw;
    logic [63:0] a, b, pa, pb;
    issue(2'b01, 1'b1, 64'hDEAD_BEEF_FFFF_FFF0,
          64'h1234_5678_0000_0003, 5'd20, 1'b1, ok);
    issue(2'b10, 1'b1, 64'hDEAD_BEEF_FFFF_FFF0,
          64'h1234_5678_0000_0003, 5'd21, 1'b1, ok);
    pop = 2'b00; pw = 1'b0; pa = 64'd1; pb = 64'd1;
    for (int i = 0; i < 30; i++) begin
      lat = $urandom_range(1, 8);
      op = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 6) == 0) a = 64'h8000_0000_8000_0000;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = '1;
        2: b = 64'($urandom_range(1, 20));
        default: b = {$urandom, $urandom};
      endcase
      if (i % 3 == 2) begin
        op = pop ^ 2'b10;
        w = pw;
        a = pa;
        b = pb;
      end
      issue(op, w, a, b, 5'(i), 1'b1, ok);
      pop = op; pw = w; pa = a; pb = b;
    end
    wait_out(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL random timeout: got %0d want %0d",
               obs.size(), sb.size());
    end
    while (sb.size() != 0 && obs.size() != 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL word/random result: got %h/%0d want %h/%0d",
                 o.res, o.tag, e.res, e.tag);
      end
    end
    lat = 5;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst_n && out_valid_o && out_ready && !flush)
          obs.push_back('{out_result_o, out_tag_o});
      end
    join_none
    test_reset();
    test_divu();
    test_reuse();
    test_special();
    test_flush_busy();
    test_backpressure();
    test_flush_done();
    test_reset_mid();
    test_word_random();
    step(3);
    n_checks++;
    if (sb.size() != 0 || obs.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d expected %0d observed want 0 0",
               sb.size(), obs.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
